// File: rtl/vga_char_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_char_sink
// Purpose  : Receiving end of the CPU character-output interface. Each rising
//            edge of videoflag captures a (position, character) pair into a
//            small FIFO. The FIFO is then drained into the character video-RAM
//            write port under a ready handshake. This decouples CPU OUTCHAR
//            timing from video-RAM availability.
// Ports    : wire_clock   - system clock, posedge
//            wire_reset   - asynchronous active-low reset
//            videoflag    - CPU write strobe (rising edge = new character)
//            bus_vga_pos  - cell index, sampled on the capture edge
//            bus_vga_char - character/colour word, sampled on the capture edge
//            vram_addr    - video RAM write address
//            vram_data    - video RAM write data
//            vram_we      - write request, held until accepted
//            vram_ready   - RAM accepts when vram_we & vram_ready at posedge
//            busy         - FIFO non-empty or write in flight
//            overflow     - sticky, a valid capture was lost to a full FIFO
//            drop_count   - saturating count of out-of-range positions
//            clear_status - synchronous clear of overflow and drop_count
// Revision : 1.0 - initial release
// ============================================================================
module vga_char_sink #(
    parameter int DEPTH        = 8,
    parameter int SCREEN_CELLS = 1200,
    parameter int ADDR_W       = 11
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    input  logic              videoflag,
    input  logic [15:0]       bus_vga_pos,
    input  logic [15:0]       bus_vga_char,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_data,
    output logic              vram_we,
    input  logic              vram_ready,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        drop_count,
    input  logic              clear_status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 16;

    localparam logic [15:0]      c_screen_cells = 16'(SCREEN_CELLS);
    localparam logic [CNT_W-1:0] c_depth        = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Capture edge detect
    // ------------------------------------------------------------------
    logic r_flag_q;
    logic w_capture;
    logic w_pos_valid;
    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_drop_event;
    logic w_ovf_event;

    // r_flag_q resets high so a strobe already asserted when reset is
    // released is ignored until it falls and rises again.
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            r_flag_q <= 1'b1;
        end else begin
            r_flag_q <= videoflag;
        end
    end

    assign w_capture    = videoflag & ~r_flag_q;
    assign w_pos_valid  = (bus_vga_pos < c_screen_cells);
    assign w_drop_event = w_capture & ~w_pos_valid;
    // Full is the pre-edge occupancy, so a pop on the same edge does not
    // make room for this push.
    assign w_push       = w_capture & w_pos_valid & ~w_full;
    assign w_ovf_event  = w_capture & w_pos_valid & w_full;

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [ENT_W-1:0] w_head;
    logic             w_pop;

    assign w_full      = (r_count == c_depth);
    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];

    // Storage needs no reset: contents are only visible through r_count.
    always_ff @(posedge wire_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus_vga_pos[ADDR_W-1:0], bus_vga_char};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   r_vram_we;
    logic   w_we_next;
    logic   w_load;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [15:0]       r_vram_data;

    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            r_state     <= ST_IDLE;
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_vram_we <= w_we_next;
            if (w_load) begin
                r_vram_addr <= w_head[ENT_W-1:16];
                r_vram_data <= w_head[15:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_we_next    = r_vram_we;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_load       = 1'b1;
                    w_we_next    = 1'b1;
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Address/data/we hold while the RAM stalls; on acceptance
                // chain straight into the next entry for back-to-back writes.
                if (vram_ready) begin
                    if (w_not_empty) begin
                        w_pop     = 1'b1;
                        w_load    = 1'b1;
                        w_we_next = 1'b1;
                    end else begin
                        w_we_next    = 1'b0;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_we_next    = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    logic       r_overflow;
    logic [7:0] r_drop_count;

    // A same-edge event beats clear_status: the clear takes effect first and
    // the event is then applied on top of the cleared value.
    always_ff @(posedge wire_clock or negedge wire_reset) begin
        if (!wire_reset) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (clear_status) begin
                r_overflow <= w_ovf_event;
            end else if (w_ovf_event) begin
                r_overflow <= 1'b1;
            end

            if (clear_status) begin
                r_drop_count <= w_drop_event ? 8'd1 : 8'd0;
            end else if (w_drop_event && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign vram_addr  = r_vram_addr;
    assign vram_data  = r_vram_data;
    assign vram_we    = r_vram_we;
    assign busy       = (r_state == ST_WRITE) | w_not_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_char_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_char_sink
// Purpose  : Self-checking bench for vga_char_sink. Expected writes are queued
//            as stimulus is driven and matched against accepted RAM writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_char_sink;

    logic        wire_clock;
    logic        wire_reset;
    logic        videoflag;
    logic [15:0] bus_vga_pos;
    logic [15:0] bus_vga_char;
    logic [10:0] vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    logic        vram_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clear_status;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_wr   = 0;
    logic [26:0] sb[$];

    vga_char_sink #(
        .DEPTH       (8),
        .SCREEN_CELLS(1200),
        .ADDR_W      (11)
    ) dut (
        .wire_clock  (wire_clock),
        .wire_reset  (wire_reset),
        .videoflag   (videoflag),
        .bus_vga_pos (bus_vga_pos),
        .bus_vga_char(bus_vga_char),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data),
        .vram_we     (vram_we),
        .vram_ready  (vram_ready),
        .busy        (busy),
        .overflow    (overflow),
        .drop_count  (drop_count),
        .clear_status(clear_status)
    );

    initial wire_clock = 1'b0;
    always #5 wire_clock = ~wire_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs only change 1 time unit after a posedge, so the negedge sees
    // exactly the values the following posedge will act on.
    always @(negedge wire_clock) begin
        logic [26:0] exp_w;
        if (wire_reset && vram_we && vram_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {5'd0, vram_addr, vram_data}, 32'hDEAD_BEEF);
            end else begin
                exp_w = sb.pop_front();
                chk("write", {5'd0, vram_addr, vram_data}, {5'd0, exp_w});
            end
            n_wr++;
        end
    end

    task automatic wait_clk();
        @(posedge wire_clock);
        #1;
    endtask

    task automatic pulse(input logic [15:0] pos, input logic [15:0] ch);
        videoflag    = 1'b1;
        bus_vga_pos  = pos;
        bus_vga_char = ch;
        wait_clk();
        videoflag    = 1'b0;
        wait_clk();
    endtask

    initial begin
        int w0;
        wire_reset   = 1'b0;
        videoflag    = 1'b0;
        bus_vga_pos  = '0;
        bus_vga_char = '0;
        vram_ready   = 1'b1;
        clear_status = 1'b0;
        repeat (2) wait_clk();

        // Reset state
        chk("rst_we",    {31'd0, vram_we}, 32'd0);
        chk("rst_addr",  {21'd0, vram_addr}, 32'd0);
        chk("rst_data",  {16'd0, vram_data}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow}, 32'd0);
        chk("rst_drop",  {24'd0, drop_count}, 32'd0);
        wire_reset = 1'b1;
        repeat (2) wait_clk();

        // Single write: strobe held 3 cycles, one capture, latency 2
        sb.push_back({11'h205, 16'h0041});
        w0 = n_wr;
        videoflag    = 1'b1;
        bus_vga_pos  = 16'h0205;
        bus_vga_char = 16'h0041;
        wait_clk();
        chk("single_we_n1", {31'd0, vram_we}, 32'd0);
        wait_clk();
        chk("single_we_n2", {31'd0, vram_we}, 32'd1);
        chk("single_addr",  {21'd0, vram_addr}, 32'h205);
        chk("single_data",  {16'd0, vram_data}, 32'h41);
        wait_clk();
        videoflag = 1'b0;
        chk("single_we_n3", {31'd0, vram_we}, 32'd0);
        chk("single_busy",  {31'd0, busy}, 32'd0);
        repeat (3) wait_clk();
        chk("single_count", n_wr - w0, 32'd1);

        // Backpressure
        vram_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back({11'(i), 16'h0030 + 16'(i)});
            pulse(16'(i), 16'h0030 + 16'(i));
        end
        chk("bp_we",   {31'd0, vram_we}, 32'd1);
        chk("bp_addr", {21'd0, vram_addr}, 32'd1);
        repeat (3) wait_clk();
        chk("bp_hold_addr", {21'd0, vram_addr}, 32'd1);
        chk("bp_hold_data", {16'd0, vram_data}, 32'h31);
        chk("bp_busy",      {31'd0, busy}, 32'd1);
        w0 = n_wr;
        vram_ready = 1'b1;
        wait_clk();
        chk("bp_b2b_we1",  {31'd0, vram_we}, 32'd1);
        chk("bp_b2b_addr", {21'd0, vram_addr}, 32'd2);
        wait_clk();
        chk("bp_b2b_we2",  {31'd0, vram_we}, 32'd1);
        wait_clk();
        chk("bp_count",    n_wr - w0, 32'd3);
        chk("bp_we_off",   {31'd0, vram_we}, 32'd0);

        // Overflow: 1 in write register + 8 in FIFO, 10th lost
        vram_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) sb.push_back({11'(i), 16'h0100 + 16'(i)});
            pulse(16'(i), 16'h0100 + 16'(i));
            if (i == 8) chk("ovf_before", {31'd0, overflow}, 32'd0);
        end
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        w0 = n_wr;
        vram_ready = 1'b1;
        repeat (12) wait_clk();
        chk("ovf_count", n_wr - w0, 32'd9);
        chk("ovf_busy",  {31'd0, busy}, 32'd0);

        // Range check
        clear_status = 1'b1;
        wait_clk();
        clear_status = 1'b0;
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        w0 = n_wr;
        sb.push_back({11'd1199, 16'h004B});
        pulse(16'd1199, 16'h004B);
        pulse(16'd1200, 16'h004C);
        repeat (4) wait_clk();
        chk("range_writes", n_wr - w0, 32'd1);
        chk("range_drop",   {24'd0, drop_count}, 32'd1);
        chk("range_ovf",    {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 300; i++) pulse(16'hFFFF, 16'h0000);
        chk("drop_sat", {24'd0, drop_count}, 32'd255);

        // Clear race: drop event on the clearing edge wins
        videoflag    = 1'b1;
        bus_vga_pos  = 16'hFFFF;
        clear_status = 1'b1;
        wait_clk();
        videoflag    = 1'b0;
        clear_status = 1'b0;
        chk("race_drop", {24'd0, drop_count}, 32'd1);
        clear_status = 1'b1;
        wait_clk();
        clear_status = 1'b0;
        chk("clr_drop",  {24'd0, drop_count}, 32'd0);
        chk("clr_ovf2",  {31'd0, overflow}, 32'd0);

        // Strobe held high across reset release is ignored
        w0 = n_wr;
        videoflag    = 1'b1;
        bus_vga_pos  = 16'd3;
        bus_vga_char = 16'h0055;
        wire_reset   = 1'b0;
        wait_clk();
        wire_reset   = 1'b1;
        repeat (4) wait_clk();
        chk("rel_no_write", n_wr - w0, 32'd0);
        chk("rel_busy",     {31'd0, busy}, 32'd0);
        videoflag = 1'b0;
        wait_clk();
        sb.push_back({11'd3, 16'h0055});
        pulse(16'd3, 16'h0055);
        repeat (4) wait_clk();
        chk("rel_write", n_wr - w0, 32'd1);

        // Reset during a stalled write
        vram_ready = 1'b0;
        sb.push_back({11'd7, 16'h0077});
        pulse(16'd7, 16'h0077);
        wait_clk();
        chk("stall_we", {31'd0, vram_we}, 32'd1);
        #2 wire_reset = 1'b0;
        #1;
        chk("async_we",   {31'd0, vram_we}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        void'(sb.pop_back());
        w0 = n_wr;
        wait_clk();
        wire_reset = 1'b1;
        vram_ready = 1'b1;
        repeat (5) wait_clk();
        chk("no_stale", n_wr - w0, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
